// File: rtl/io_input_port_if.sv
// rtl/io_input_port_if.sv - read-request bus between the CPU I/O load path and io_input_port
interface io_input_port_if #(
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;
  logic              rvalid;

  modport master (output rd_en, output addr, input rdata, input rvalid);
  modport slave  (input rd_en, input addr, output rdata, output rvalid);
endinterface

// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - synchronized, debounced switch/key input port with sticky key-press events
// Optional IO_INPUT_IRQ_EN adds a registered irq output = |events.
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [9:0]         sw,
  input  logic [3:1]         key,
  io_input_port_if.slave     bus
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int NB = 13;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Keys are active-low, so their idle (released) level is 1 in every stage.
  localparam logic [NB-1:0] IDLE = {3'b111, 10'b0};

  localparam logic [ADDR_W-3:0] WS_SW   = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] WS_KEY  = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] WS_EVT  = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] WS_BUSY = (ADDR_W-2)'(3);

  logic [NB-1:0]     sync1, sync2;
  logic [NB-1:0]     deb, deb_nx;
  logic [CW-1:0]     cnt    [NB];
  logic [CW-1:0]     cnt_nx [NB];
  logic [NB-1:0]     busy;
  logic [3:1]        pressed;
  logic [3:1]        press_set;
  logic [3:1]        events, events_nx;
  logic [ADDR_W-3:0] word_sel;
  logic              rd_clr;
  logic [31:0]       rd_word;
  logic              unused_addr_bits;

  assign word_sel         = bus.addr[ADDR_W-1:2];
  assign unused_addr_bits = ^bus.addr[1:0];
  assign pressed          = ~deb[12:10];

  always_comb begin
    deb_nx = deb;
    busy   = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_nx[i] = '0;
      busy[i]   = (cnt[i] != '0);
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_MAX) begin
          deb_nx[i] = sync2[i];
        end else begin
          cnt_nx[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is the debounced key falling; setting wins over a same-edge read-clear.
  assign press_set = deb[12:10] & ~deb_nx[12:10];
  assign rd_clr    = bus.rd_en && (word_sel == WS_EVT);
  assign events_nx = (rd_clr ? 3'b000 : events) | press_set;

  always_comb begin
    rd_word = '0;
    case (word_sel)
      WS_SW:   rd_word = {22'b0, deb[9:0]};
      WS_KEY:  rd_word = {29'b0, pressed};
      WS_EVT:  rd_word = {29'b0, events};
      WS_BUSY: rd_word = {19'b0, busy};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1      <= IDLE;
      sync2      <= IDLE;
      deb        <= IDLE;
      events     <= '0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= {key, sw};
      sync2      <= sync1;
      deb        <= deb_nx;
      events     <= events_nx;
      bus.rvalid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rdata <= rd_word;
      end
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= cnt_nx[i];
      end
    end
  end

`ifdef IO_INPUT_IRQ_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |events;
    end
  end
`endif

endmodule
